// File: rtl/sm_step_pkg.sv
// Shared types and default sizing for the multi-channel stepper step generator.
// Included by the channel core and the top-level wrapper.
package sm_step_pkg;

    localparam int SM_NCH     = 4;
    localparam int SM_SIZE    = 16;
    localparam int SM_CNTW    = 32;
    localparam int SM_PULSE_W = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        MODE_CONT    = 1'b0,
        MODE_COUNTED = 1'b1
    } mode_t;

endpackage

// File: rtl/sm_step_chan.sv
// One step/direction channel: FSM, period counter, shadowed period reload with
// minimum-period clamp, and the issued-step counter.
module sm_step_chan
    import sm_step_pkg::*;
#(
    parameter int SIZE    = SM_SIZE,
    parameter int CNTW    = SM_CNTW,
    parameter int PULSE_W = SM_PULSE_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [SIZE-1:0] period_in,
    input  logic            enable,
    input  logic            mode,
    input  logic            start,
    input  logic            dir_in,
    input  logic [CNTW-1:0] step_target,
    output logic            drv_step,
    output logic            drv_dir,
    output logic            busy,
    output logic            done,
    output logic [CNTW-1:0] step_count
);

    localparam logic [SIZE-1:0] HIGH_CLKS  = SIZE'(PULSE_W);
    localparam logic [SIZE-1:0] MIN_PERIOD = SIZE'(PULSE_W + 1);

    // A period shorter than the pulse plus one low clock is stretched so the
    // driver always sees a falling edge between steps.
    function automatic logic [SIZE-1:0] clamp_period(input logic [SIZE-1:0] p);
        return (p < MIN_PERIOD) ? MIN_PERIOD : p;
    endfunction

    state_t          state;
    mode_t           mode_r;
    logic [SIZE-1:0] shadow;
    logic [SIZE-1:0] active;
    logic [SIZE-1:0] cnt;
    logic [SIZE-1:0] p_eff;
    logic [SIZE-1:0] next_period;
    logic [CNTW-1:0] target;
    logic [CNTW-1:0] count_inc;
    logic            accept;
    logic            last;
    logic            final_step;

    assign p_eff       = clamp_period(active);
    assign last        = (cnt == p_eff - SIZE'(1));
    // A load landing on the boundary cycle goes straight to the next period.
    assign next_period = load ? period_in : shadow;
    assign accept      = (state == IDLE) && start && enable;
    assign count_inc   = step_count + CNTW'(1);
    assign final_step  = (mode_r == MODE_COUNTED) && (count_inc == target);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            drv_step   <= 1'b0;
            drv_dir    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            step_count <= '0;
            shadow     <= '0;
        end else begin
            if (load) begin
                shadow <= period_in;
            end
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    drv_step <= 1'b0;
                    busy     <= 1'b0;
                    if (accept) begin
                        state      <= SETUP;
                        drv_dir    <= dir_in;
                        step_count <= '0;
                        busy       <= 1'b1;
                    end
                end
                SETUP: begin
                    if (!enable) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if ((mode_r == MODE_COUNTED) && (target == '0)) begin
                        state <= DONE;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        drv_step <= 1'b0;
                    end else begin
                        drv_step <= (cnt < HIGH_CLKS);
                        if (last) begin
                            step_count <= count_inc;
                            if (final_step) begin
                                state <= DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    drv_step <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Datapath registers: always written before use, so no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            mode_r <= mode_t'(mode);
            target <= step_target;
            active <= next_period;
        end else if ((state == RUN) && last) begin
            active <= next_period;
        end
        if (state == SETUP) begin
            cnt <= '0;
        end else if (state == RUN) begin
            cnt <= last ? '0 : cnt + SIZE'(1);
        end
    end

endmodule

// File: rtl/sm_step_gen.sv
// Multi-channel step/direction pulse generator: NCH independent channels
// sharing one period-load trigger, with packed per-channel buses.
module sm_step_gen
    import sm_step_pkg::*;
#(
    parameter int NCH     = SM_NCH,
    parameter int SIZE    = SM_SIZE,
    parameter int CNTW    = SM_CNTW,
    parameter int PULSE_W = SM_PULSE_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                data_valid_trig,
    input  logic [NCH-1:0]      load_mask,
    input  logic [NCH*SIZE-1:0] period_in,
    input  logic [NCH-1:0]      in_drv_enable_SM,
    input  logic [NCH-1:0]      mode,
    input  logic [NCH-1:0]      start,
    input  logic [NCH-1:0]      dir_in,
    input  logic [NCH*CNTW-1:0] step_target,
    output logic [NCH-1:0]      drv_step,
    output logic [NCH-1:0]      drv_dir,
    output logic [NCH-1:0]      busy,
    output logic [NCH-1:0]      done,
    output logic [NCH*CNTW-1:0] step_count
);

    genvar i;
    generate
        for (i = 0; i < NCH; i++) begin : g_chan
            sm_step_chan #(
                .SIZE    (SIZE),
                .CNTW    (CNTW),
                .PULSE_W (PULSE_W)
            ) u_chan (
                .clk         (clk),
                .rst         (rst),
                .load        (data_valid_trig & load_mask[i]),
                .period_in   (period_in[i*SIZE +: SIZE]),
                .enable      (in_drv_enable_SM[i]),
                .mode        (mode[i]),
                .start       (start[i]),
                .dir_in      (dir_in[i]),
                .step_target (step_target[i*CNTW +: CNTW]),
                .drv_step    (drv_step[i]),
                .drv_dir     (drv_dir[i]),
                .busy        (busy[i]),
                .done        (done[i]),
                .step_count  (step_count[i*CNTW +: CNTW])
            );
        end
    endgenerate

endmodule

// File: tb/tb_sm_step_gen.sv
// Directed bench for sm_step_gen: expected channel-0 step rises and done
// strobes are queued as stimulus is driven and checked when the DUT emits them.
module tb_sm_step_gen;

    localparam int NCH  = 4;
    localparam int SIZE = 16;
    localparam int CNTW = 32;
    localparam int PW   = 10;

    logic                clk = 1'b0;
    logic                rst;
    logic                data_valid_trig;
    logic [NCH-1:0]      load_mask;
    logic [NCH*SIZE-1:0] period_in;
    logic [NCH-1:0]      in_drv_enable_SM;
    logic [NCH-1:0]      mode;
    logic [NCH-1:0]      start;
    logic [NCH-1:0]      dir_in;
    logic [NCH*CNTW-1:0] step_target;
    logic [NCH-1:0]      drv_step;
    logic [NCH-1:0]      drv_dir;
    logic [NCH-1:0]      busy;
    logic [NCH-1:0]      done;
    logic [NCH*CNTW-1:0] step_count;

    sm_step_gen #(.NCH(NCH), .SIZE(SIZE), .CNTW(CNTW), .PULSE_W(PW)) dut (
        .clk              (clk),
        .rst              (rst),
        .data_valid_trig  (data_valid_trig),
        .load_mask        (load_mask),
        .period_in        (period_in),
        .in_drv_enable_SM (in_drv_enable_SM),
        .mode             (mode),
        .start            (start),
        .dir_in           (dir_in),
        .step_target      (step_target),
        .drv_step         (drv_step),
        .drv_dir          (drv_dir),
        .busy             (busy),
        .done             (done),
        .step_count       (step_count)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int width; } rise_t;
    typedef struct { int cyc; longint cnt; } done_t;
    rise_t rise_q[$];
    done_t done_q[$];

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) tick(1);
    endtask

    task automatic load(input int ch, input int p);
        period_in[ch*SIZE +: SIZE] = SIZE'(p);
        load_mask = NCH'(1 << ch);
        data_valid_trig = 1'b1;
        tick(1);
        data_valid_trig = 1'b0;
        load_mask = '0;
    endtask

    task automatic start_ch(input logic [NCH-1:0] m, output int k);
        start = m;
        tick(1);
        start = '0;
        k = cyc;
    endtask

    task automatic exp_rise(input int c, input int w);
        rise_t r;
        r.cyc = c;
        r.width = w;
        rise_q.push_back(r);
    endtask

    task automatic exp_done(input int c, input longint n);
        done_t d;
        d.cyc = c;
        d.cnt = n;
        done_q.push_back(d);
    endtask

    // Channel-0 monitor, sampling on the falling edge.
    logic  prev_step = 1'b0;
    int    rise_at = 0;
    int    rise_w = 0;
    rise_t mon_r;
    done_t mon_d;
    always @(negedge clk) begin
        if (drv_step[0] && !prev_step) begin
            if (rise_q.size() == 0) begin
                check("rise_unexpected", cyc, -1);
            end else begin
                mon_r = rise_q.pop_front();
                check("rise_cyc", cyc, mon_r.cyc);
                rise_at = cyc;
                rise_w = mon_r.width;
            end
        end
        if (!drv_step[0] && prev_step) begin
            check("pulse_width", cyc - rise_at, rise_w);
        end
        if (done[0]) begin
            if (done_q.size() == 0) begin
                check("done_unexpected", cyc, -1);
            end else begin
                mon_d = done_q.pop_front();
                check("done_cyc", cyc, mon_d.cyc);
                check("done_count", step_count[CNTW-1:0], mon_d.cnt);
            end
        end
        prev_step = drv_step[0];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int kk;
        rst = 1'b0;
        data_valid_trig = 1'b0;
        load_mask = '0;
        period_in = '0;
        in_drv_enable_SM = '1;
        mode = '0;
        start = '0;
        dir_in = '0;
        step_target = '0;
        tick(3);
        check("rst_step", drv_step, 0);
        check("rst_dir", drv_dir, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", longint'(|step_count), 0);
        rst = 1'b1;
        tick(2);

        // Continuous, period 50, then mid-period reload to 30, then boundary reload to 20
        load(0, 50);
        mode[0] = 1'b0;
        dir_in[0] = 1'b1;
        start_ch(4'b0001, k);
        check("t1_dir", drv_dir[0], 1);
        check("t1_busy", busy[0], 1);
        check("t1_step_low", drv_step[0], 0);
        exp_rise(k + 2, PW);
        exp_rise(k + 52, PW);
        wait_to(k + 50);
        check("t1_count_before", step_count[CNTW-1:0], 0);
        tick(1);
        check("t1_count_first", step_count[CNTW-1:0], 1);
        wait_to(k + 70);
        exp_rise(k + 102, PW);
        exp_rise(k + 132, PW);
        load(0, 30);
        wait_to(k + 101);
        check("t1_count_second", step_count[CNTW-1:0], 2);
        wait_to(k + 160);
        exp_rise(k + 162, PW);
        exp_rise(k + 182, 3);
        load(0, 20);
        wait_to(k + 184);
        in_drv_enable_SM[0] = 1'b0;
        tick(1);
        check("abort_busy", busy[0], 0);
        check("abort_step", drv_step[0], 0);
        check("abort_count", step_count[CNTW-1:0], 5);
        tick(5);
        check("abort_count_hold", step_count[CNTW-1:0], 5);

        // Start with enable low is ignored
        start_ch(4'b0001, kk);
        check("start_dis_busy", busy[0], 0);
        tick(3);
        in_drv_enable_SM[0] = 1'b1;
        tick(1);

        // Counted, target 3, period 20; a second start while busy is ignored
        load(0, 20);
        mode[0] = 1'b1;
        step_target[CNTW-1:0] = 3;
        dir_in[0] = 1'b0;
        start_ch(4'b0001, k);
        check("t2_dir", drv_dir[0], 0);
        check("t2_count_cleared", step_count[CNTW-1:0], 0);
        exp_rise(k + 2, PW);
        exp_rise(k + 22, PW);
        exp_rise(k + 42, PW);
        exp_done(k + 62, 3);
        wait_to(k + 30);
        dir_in[0] = 1'b1;
        start_ch(4'b0001, kk);
        dir_in[0] = 1'b0;
        check("start_busy_dir", drv_dir[0], 0);
        wait_to(k + 61);
        check("t2_busy_before_done", busy[0], 1);
        tick(1);
        check("t2_busy_at_done", busy[0], 0);
        tick(1);
        check("t2_done_one_cycle", done[0], 0);
        wait_to(k + 70);

        // Period 4 clamps to 11 clocks
        load(0, 4);
        mode[0] = 1'b0;
        start_ch(4'b0001, k);
        exp_rise(k + 2, PW);
        exp_rise(k + 13, PW);
        exp_rise(k + 24, PW);
        exp_rise(k + 35, 3);
        wait_to(k + 37);
        in_drv_enable_SM[0] = 1'b0;
        tick(1);
        in_drv_enable_SM[0] = 1'b1;
        check("t3_abort_busy", busy[0], 0);
        tick(2);

        // Period 0 clamps to 11 clocks, counted target 3
        load(0, 0);
        mode[0] = 1'b1;
        step_target[CNTW-1:0] = 3;
        start_ch(4'b0001, k);
        exp_rise(k + 2, PW);
        exp_rise(k + 13, PW);
        exp_rise(k + 24, PW);
        exp_done(k + 35, 3);
        wait_to(k + 40);

        // Counted target 0: done after SETUP, no step
        step_target[CNTW-1:0] = 0;
        start_ch(4'b0001, k);
        exp_done(k + 2, 0);
        check("t0_busy", busy[0], 1);
        wait_to(k + 3);
        check("t0_busy_after", busy[0], 0);
        check("t0_count", step_count[CNTW-1:0], 0);
        tick(2);

        // All channels running, reset asserted mid-pulse on channel 0
        load(0, 20);
        load(1, 30);
        load(2, 40);
        load(3, 25);
        mode = '0;
        dir_in = 4'b1011;
        start_ch(4'b1111, k);
        check("t4_dir", drv_dir, 4'b1011);
        check("t4_busy", busy, 4'b1111);
        exp_rise(k + 2, PW);
        exp_rise(k + 22, 3);
        wait_to(k + 25);
        check("t4_pre_rst_step", drv_step[0], 1);
        rst = 1'b0;
        #1;
        check("t4_rst_step", drv_step, 0);
        check("t4_rst_busy", busy, 0);
        check("t4_rst_dir", drv_dir, 0);
        check("t4_rst_count", longint'(|step_count), 0);
        tick(2);
        rst = 1'b1;
        tick(1);

        // Restart only channels 1 and 2; the others stay idle
        load(1, 30);
        load(2, 40);
        dir_in = 4'b0110;
        start_ch(4'b0110, k);
        check("t5_busy", busy, 4'b0110);
        check("t5_dir", drv_dir, 4'b0110);
        wait_to(k + 31);
        check("t5_ch1_cnt1", step_count[CNTW +: CNTW], 1);
        check("t5_ch2_cnt0", step_count[2*CNTW +: CNTW], 0);
        wait_to(k + 41);
        check("t5_ch2_cnt1", step_count[2*CNTW +: CNTW], 1);
        wait_to(k + 61);
        check("t5_ch1_cnt2", step_count[CNTW +: CNTW], 2);
        check("t5_ch2_cnt_still1", step_count[2*CNTW +: CNTW], 1);
        check("t5_idle_busy", busy & 4'b1001, 0);
        check("t5_ch0_count", step_count[CNTW-1:0], 0);
        in_drv_enable_SM = '0;
        tick(1);
        check("t5_abort_busy", busy, 0);
        in_drv_enable_SM = '1;
        tick(3);

        check("rise_queue_drained", rise_q.size(), 0);
        check("done_queue_drained", done_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
